// File: rtl/somador_32_bits.sv
// somador_32_bits: 32-bit adder with carry-in, built from eight 4-bit
// carry-lookahead groups whose group carries ripple from one group to the next.
// Outputs are sum, carry-out, sign and signed overflow, plus a sticky
// overflow status bit.
// Optional macro PIPELINE_EN: registers S/Cout/Signal/Overflow, giving one
// cycle of latency. The sticky bit then accumulates the registered flag.
module somador_32_bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout,
    output logic        Signal,
    output logic        Overflow,
    input  logic        ovf_clr,
    output logic        ovf_sticky
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_sign;
    logic        w_ovf;
    logic        w_ovf_out;
    logic        r_ovf_sticky;

    assign w_g    = A & B;
    assign w_p    = A ^ B;
    assign w_c[0] = Cin;

    // Inside each group, every carry is expanded in terms of the group's carry-in.
    // This keeps the lookahead depth fixed at one group.
    for (genvar gi = 0; gi < 8; gi++) begin : g_cla
        localparam int BASE = gi * 4;
        assign w_c[BASE+1] = w_g[BASE]
                           | (w_p[BASE] & w_c[BASE]);
        assign w_c[BASE+2] = w_g[BASE+1]
                           | (w_p[BASE+1] & w_g[BASE])
                           | (w_p[BASE+1] & w_p[BASE] & w_c[BASE]);
        assign w_c[BASE+3] = w_g[BASE+2]
                           | (w_p[BASE+2] & w_g[BASE+1])
                           | (w_p[BASE+2] & w_p[BASE+1] & w_g[BASE])
                           | (w_p[BASE+2] & w_p[BASE+1] & w_p[BASE] & w_c[BASE]);
        assign w_c[BASE+4] = w_g[BASE+3]
                           | (w_p[BASE+3] & w_g[BASE+2])
                           | (w_p[BASE+3] & w_p[BASE+2] & w_g[BASE+1])
                           | (w_p[BASE+3] & w_p[BASE+2] & w_p[BASE+1] & w_g[BASE])
                           | (w_p[BASE+3] & w_p[BASE+2] & w_p[BASE+1] & w_p[BASE] & w_c[BASE]);
    end

    assign w_sum  = w_p ^ w_c[31:0];
    assign w_cout = w_c[32];
    // The sign flag comes from the result itself, not from the operands.
    assign w_sign = w_sum[31];
    // Signed overflow: both operands have the same sign and the result's sign differs.
    assign w_ovf  = (A[31] == B[31]) && (w_sum[31] != A[31]);

`ifdef PIPELINE_EN
    logic [31:0] r_s;
    logic        r_cout;
    logic        r_sign;
    logic        r_ovf;

    // Output stage: registers the arithmetic results, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= 32'h0;
            r_cout <= 1'b0;
            r_sign <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_cout;
            r_sign <= w_sign;
            r_ovf  <= w_ovf;
        end
    end

    assign S         = r_s;
    assign Cout      = r_cout;
    assign Signal    = r_sign;
    assign w_ovf_out = r_ovf;
`else
    assign S         = w_sum;
    assign Cout      = w_cout;
    assign Signal    = w_sign;
    assign w_ovf_out = w_ovf;
`endif

    assign Overflow = w_ovf_out;

    // Sticky overflow status: clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky | w_ovf_out;
        end
    end

    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_somador_32_bits.sv
// Testbench for somador_32_bits. Every vector that is driven pushes its
// expected result onto a scoreboard queue. The expected result is popped and
// compared once the DUT output is valid, which is immediately in the
// combinational build and one clk later under PIPELINE_EN.
module tb_somador_32_bits;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        sign;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;
    logic        Signal;
    logic        Overflow;
    logic        ovf_clr;
    logic        ovf_sticky;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    somador_32_bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .Cin        (Cin),
        .S          (S),
        .Cout       (Cout),
        .Signal     (Signal),
        .Overflow   (Overflow),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
        exp_t        e;
        logic [32:0] full;
        full   = {1'b0, a} + {1'b0, b} + {32'h0, c};
        e.s    = full[31:0];
        e.cout = full[32];
        e.sign = full[31];
        e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        return e;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic drive_push(input logic [31:0] a, input logic [31:0] b, input logic c);
        A   = a;
        B   = b;
        Cin = c;
        sb_q.push_back(model(a, b, c));
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk32({tag, "_S"}, S, e.s);
            chk1({tag, "_Cout"}, Cout, e.cout);
            chk1({tag, "_Signal"}, Signal, e.sign);
            chk1({tag, "_Overflow"}, Overflow, e.ovf);
        end
    endtask

    // Drives one vector in the low clock phase and checks it once the output is valid.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        drive_push(a, b, c);
`ifdef PIPELINE_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        check_pop(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        ovf_clr = 1'b0;
        A       = 32'h0;
        B       = 32'h0;
        Cin     = 1'b0;
        #12;
        chk1("reset_sticky", ovf_sticky, 1'b0);
        chk32("reset_S", S, 32'h0);
        chk1("reset_Cout", Cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("t1", 32'h0000_0001, 32'h3FFF_FFFF, 1'b0);
        @(posedge clk); #1;
        chk1("t1_sticky", ovf_sticky, 1'b0);

        apply("t2_ovf", 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        chk32("t2_S_const", S, 32'h8000_0000);
        chk1("t2_Overflow_const", Overflow, 1'b1);
        @(posedge clk); #1;
        chk1("t2_sticky_set", ovf_sticky, 1'b1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        chk1("t2_sticky_clr_priority", ovf_sticky, 1'b0);
        @(negedge clk);
        ovf_clr = 1'b0;
        @(posedge clk); #1;
        chk1("t2_sticky_reset_again", ovf_sticky, 1'b1);

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("rst_pulse_sticky", ovf_sticky, 1'b0);
        drive_push(32'h0000_0001, 32'h3FFF_FFFF, 1'b0);
        #1;
`ifdef PIPELINE_EN
        chk32("rst_pulse_S_zero", S, 32'h0);
        chk1("rst_pulse_Overflow_zero", Overflow, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_pop("rst_pulse_follow");
`else
        check_pop("rst_pulse_follow");
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        chk1("rst_pulse_sticky_after", ovf_sticky, 1'b0);

        apply("t3_cin0", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        apply("t3_cin1", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        apply("t4_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        chk32("t4_S_const", S, 32'h0);
        chk1("t4_Cout_const", Cout, 1'b1);
        apply("t5_cin0", 32'h0000_0001, 32'h0000_0001, 1'b0);
        apply("t5_cin1", 32'h0000_0001, 32'h0000_0001, 1'b1);
        apply("max_max_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk32("max_S_const", S, 32'hFFFF_FFFF);
        chk1("max_Cout_const", Cout, 1'b1);
        apply("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0);
        apply("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        apply("group_carry", 32'h0FFF_FFFF, 32'h0000_0000, 1'b1);

        for (int i = 0; i < 24; i++) begin
            apply("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Upper bound on run time so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
